// File: rtl/mat_mul_pkg.sv
// Shared types and defaults for the matrix-multiply address sequencer.
// Holds the FSM state encoding, default dimensions and a width helper.
package mat_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mat_state_e;

  localparam int MAT_M_DEF = 1;
  localparam int MAT_K_DEF = 8;
  localparam int MAT_N_DEF = 16;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mat_wrap_cnt.sv
// Modulo-MAX counter with increment, synchronous clear and a wrap strobe
// used to chain the k -> j -> i loop counters.
module mat_wrap_cnt
  import mat_mul_pkg::*;
#(
  parameter int MAX = 2,
  localparam int W = clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         first_o,
  output logic         last_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == LAST);
  assign wrap_o  = inc_i & last_o;

endmodule

// File: rtl/mat_addr_gen.sv
// A/B read-address sequencer for C = A*B, walking i/j/k with a start/done handshake.
// Optional C write-back addressing is compiled in with MAT_ADDR_GEN_WB_EN.
module mat_addr_gen
  import mat_mul_pkg::*;
#(
  parameter int M_DIM = MAT_M_DEF,
  parameter int K_DIM = MAT_K_DEF,
  parameter int N_DIM = MAT_N_DEF,
  localparam int AW_A = clog2_min1(M_DIM * K_DIM),
  localparam int AW_B = clog2_min1(K_DIM * N_DIM),
  localparam int AW_C = clog2_min1(M_DIM * N_DIM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            addr_ready,
  output logic            addr_valid,
  output logic [AW_A-1:0] addr_a,
  output logic [AW_B-1:0] addr_b,
  output logic            first_k,
  output logic            last_k,
  output logic            busy,
  output logic            done
`ifdef MAT_ADDR_GEN_WB_EN
  ,
  output logic [AW_C-1:0] addr_c,
  output logic            c_we
`endif
);

  localparam int WI = clog2_min1(M_DIM);
  localparam int WJ = clog2_min1(N_DIM);
  localparam int WK = clog2_min1(K_DIM);

  // Steps only used when they fit: K_STEP needs M_DIM>1, N_STEP needs K_DIM>1.
  localparam logic [AW_A-1:0] K_STEP = AW_A'(K_DIM);
  localparam logic [AW_B-1:0] N_STEP = AW_B'(N_DIM);

  mat_state_e state_q, state_d;

  logic [AW_A-1:0] a_base_q, a_base_d;
  logic [AW_A-1:0] addr_a_q, addr_a_d;
  logic [AW_B-1:0] addr_b_q, addr_b_d;

  logic beat, start_run;
  logic k_first, k_last, k_wrap, j_wrap, i_wrap;
  logic [WJ-1:0] j_cnt;
  logic [WK-1:0] unused_k_cnt;
  logic [WI-1:0] unused_i_cnt;
  logic unused_j_first, unused_j_last, unused_i_first, unused_i_last;

  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign beat       = addr_valid & addr_ready;
  assign start_run  = (state_q == IDLE) & start;

  mat_wrap_cnt #(.MAX(K_DIM)) u_k_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_run),
    .inc_i   (beat),
    .cnt_o   (unused_k_cnt),
    .first_o (k_first),
    .last_o  (k_last),
    .wrap_o  (k_wrap)
  );

  mat_wrap_cnt #(.MAX(N_DIM)) u_j_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_run),
    .inc_i   (k_wrap),
    .cnt_o   (j_cnt),
    .first_o (unused_j_first),
    .last_o  (unused_j_last),
    .wrap_o  (j_wrap)
  );

  mat_wrap_cnt #(.MAX(M_DIM)) u_i_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_run),
    .inc_i   (j_wrap),
    .cnt_o   (unused_i_cnt),
    .first_o (unused_i_first),
    .last_o  (unused_i_last),
    .wrap_o  (i_wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (i_wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Incremental addressing: the final beat wraps every register back to zero.
  always_comb begin
    a_base_d = a_base_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    if (beat) begin
      if (i_wrap) begin
        a_base_d = '0;
        addr_a_d = '0;
        addr_b_d = '0;
      end else if (j_wrap) begin
        a_base_d = a_base_q + K_STEP;
        addr_a_d = a_base_q + K_STEP;
        addr_b_d = '0;
      end else if (k_wrap) begin
        addr_a_d = a_base_q;
        addr_b_d = AW_B'(j_cnt) + AW_B'(1);
      end else begin
        addr_a_d = addr_a_q + AW_A'(1);
        addr_b_d = addr_b_q + N_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_base_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      state_q  <= state_d;
      a_base_q <= a_base_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  assign addr_a  = addr_a_q;
  assign addr_b  = addr_b_q;
  assign first_k = addr_valid & k_first;
  assign last_k  = addr_valid & k_last;

`ifdef MAT_ADDR_GEN_WB_EN
  // c_idx tracks i*N_DIM+j of the dot product in flight; published one cycle after its last_k beat.
  logic [AW_C-1:0] c_idx_q, c_idx_d;
  logic [AW_C-1:0] addr_c_q, addr_c_d;
  logic            c_we_q, c_we_d;

  always_comb begin
    c_idx_d  = c_idx_q;
    addr_c_d = addr_c_q;
    c_we_d   = beat & k_wrap;
    if (beat & k_wrap) begin
      addr_c_d = c_idx_q;
      c_idx_d  = i_wrap ? '0 : c_idx_q + AW_C'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_idx_q  <= '0;
      addr_c_q <= '0;
      c_we_q   <= 1'b0;
    end else begin
      c_idx_q  <= c_idx_d;
      addr_c_q <= addr_c_d;
      c_we_q   <= c_we_d;
    end
  end

  assign addr_c = addr_c_q;
  assign c_we   = c_we_q;
`endif

endmodule

// File: tb/tb_mat_addr_gen.sv
// Randomised bench for mat_addr_gen: three instances (1x8x16, 2x3x2, 1x1x1)
// checked beat-by-beat against an index-arithmetic reference model.
module tb_mat_addr_gen;

  logic clk = 1'b0;
  logic rst;
  logic start_s [3];
  logic ready_s [3];

  int valid_w [3], a_w [3], b_w [3], fk_w [3], lk_w [3], busy_w [3], done_w [3];
  int cwe_w [3], c_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic       v0, fk0, lk0, bz0, dn0;
  logic [2:0] a0;
  logic [6:0] b0;
  logic       v1, fk1, lk1, bz1, dn1;
  logic [2:0] a1;
  logic [2:0] b1;
  logic       v2, fk2, lk2, bz2, dn2;
  logic [0:0] a2;
  logic [0:0] b2;
`ifdef MAT_ADDR_GEN_WB_EN
  logic [3:0] c0;
  logic [1:0] c1;
  logic [0:0] c2;
  logic       we0, we1, we2;
  assign cwe_w[0] = int'(we0); assign c_w[0] = int'(c0);
  assign cwe_w[1] = int'(we1); assign c_w[1] = int'(c1);
  assign cwe_w[2] = int'(we2); assign c_w[2] = int'(c2);
`else
  assign cwe_w[0] = 0; assign c_w[0] = 0;
  assign cwe_w[1] = 0; assign c_w[1] = 0;
  assign cwe_w[2] = 0; assign c_w[2] = 0;
`endif

  mat_addr_gen #(.M_DIM(1), .K_DIM(8), .N_DIM(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .addr_ready(ready_s[0]),
    .addr_valid(v0), .addr_a(a0), .addr_b(b0), .first_k(fk0), .last_k(lk0),
    .busy(bz0), .done(dn0)
`ifdef MAT_ADDR_GEN_WB_EN
    , .addr_c(c0), .c_we(we0)
`endif
  );

  mat_addr_gen #(.M_DIM(2), .K_DIM(3), .N_DIM(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .addr_ready(ready_s[1]),
    .addr_valid(v1), .addr_a(a1), .addr_b(b1), .first_k(fk1), .last_k(lk1),
    .busy(bz1), .done(dn1)
`ifdef MAT_ADDR_GEN_WB_EN
    , .addr_c(c1), .c_we(we1)
`endif
  );

  mat_addr_gen #(.M_DIM(1), .K_DIM(1), .N_DIM(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .addr_ready(ready_s[2]),
    .addr_valid(v2), .addr_a(a2), .addr_b(b2), .first_k(fk2), .last_k(lk2),
    .busy(bz2), .done(dn2)
`ifdef MAT_ADDR_GEN_WB_EN
    , .addr_c(c2), .c_we(we2)
`endif
  );

  assign valid_w[0] = int'(v0); assign a_w[0] = int'(a0); assign b_w[0] = int'(b0);
  assign fk_w[0] = int'(fk0); assign lk_w[0] = int'(lk0);
  assign busy_w[0] = int'(bz0); assign done_w[0] = int'(dn0);
  assign valid_w[1] = int'(v1); assign a_w[1] = int'(a1); assign b_w[1] = int'(b1);
  assign fk_w[1] = int'(fk1); assign lk_w[1] = int'(lk1);
  assign busy_w[1] = int'(bz1); assign done_w[1] = int'(dn1);
  assign valid_w[2] = int'(v2); assign a_w[2] = int'(a2); assign b_w[2] = int'(b2);
  assign fk_w[2] = int'(fk2); assign lk_w[2] = int'(lk2);
  assign busy_w[2] = int'(bz2); assign done_w[2] = int'(dn2);

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    check_eq({tag, " valid"}, valid_w[s], 0);
    check_eq({tag, " busy"}, busy_w[s], 0);
    check_eq({tag, " done"}, done_w[s], 0);
    check_eq({tag, " addr_a"}, a_w[s], 0);
    check_eq({tag, " addr_b"}, b_w[s], 0);
    check_eq({tag, " first_k"}, fk_w[s], 0);
    check_eq({tag, " last_k"}, lk_w[s], 0);
    check_eq({tag, " c_we"}, cwe_w[s], 0);
  endtask

  // One complete multiply on instance s. Beat n maps to (i,j,k) by plain division:
  // k = n%K, j = (n/K)%N, i = n/(K*N); a = i*K+k, b = k*N+j, c = i*N+j.
  task automatic run_check(input int s, input int m, input int kd, input int nd,
                           input int ready_pct, input bit hold, input bit poke);
    int total = m * kd * nd;
    int n = 0;
    int cyc = 0;
    int ii, jj, kk;
    bit rdy;
    bit prev_lk = 0;
    int pend_c = 0;
    int wb_cnt = 0;
    @(posedge clk); #1;
    start_s[s] = 1'b1;
    ready_s[s] = 1'b0;
    while (n < total && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) start_s[s] = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      kk = n % kd;
      jj = (n / kd) % nd;
      ii = n / (kd * nd);
      check_eq("valid", valid_w[s], 1);
      check_eq("busy", busy_w[s], 1);
      check_eq("done_in_run", done_w[s], 0);
      check_eq("addr_a", a_w[s], ii * kd + kk);
      check_eq("addr_b", b_w[s], kk * nd + jj);
      check_eq("first_k", fk_w[s], (kk == 0) ? 1 : 0);
      check_eq("last_k", lk_w[s], (kk == kd - 1) ? 1 : 0);
`ifdef MAT_ADDR_GEN_WB_EN
      check_eq("c_we", cwe_w[s], int'(prev_lk));
      if (prev_lk) begin
        check_eq("addr_c", c_w[s], pend_c);
        wb_cnt++;
      end
`endif
      rdy = ($urandom_range(0, 99) < ready_pct);
      ready_s[s] = rdy;
      prev_lk = rdy && (kk == kd - 1);
      if (prev_lk) pend_c = ii * nd + jj;
      if (rdy) n++;
    end
    check_eq("beat_budget", (cyc < 4000) ? 1 : 0, 1);
    @(posedge clk); #1;
    if (!hold) start_s[s] = 1'b0;
    ready_s[s] = 1'b0;
    check_eq("end_valid", valid_w[s], 0);
    check_eq("end_busy", busy_w[s], 0);
    check_eq("done_pulse", done_w[s], 1);
`ifdef MAT_ADDR_GEN_WB_EN
    check_eq("final_c_we", cwe_w[s], 1);
    check_eq("final_addr_c", c_w[s], pend_c);
    wb_cnt++;
    check_eq("wb_count", wb_cnt, m * nd);
`endif
    @(posedge clk); #1;
    check_eq("done_cleared", done_w[s], 0);
    check_eq("idle_valid", valid_w[s], 0);
    $display("run inst=%0d dims=%0dx%0dx%0d ready=%0d%% beats=%0d cycles=%0d",
             s, m, kd, nd, ready_pct, n, cyc);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_idle(0, "reset");
    check_idle(1, "reset1");
    rst = 1'b0;

    // Abort a run with a two-cycle reset; no done may follow.
    start_s[0] = 1'b1;
    ready_s[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("pre_abort_valid", valid_w[0], 1);
    start_s[0] = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check_idle(0, "abort");
    end
    rst = 1'b0;
    ready_s[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_idle(0, "post_abort");
    end
    $display("reset-abort sequence complete");

    run_check(0, 1, 8, 16, 100, 1'b0, 1'b0);
    run_check(0, 1, 8, 16, 50, 1'b0, 1'b0);
    run_check(1, 2, 3, 2, 70, 1'b0, 1'b0);
    run_check(1, 2, 3, 2, 100, 1'b0, 1'b0);

    // Degenerate 1x1x1 with start held: one IDLE cycle, then the rerun.
    run_check(2, 1, 1, 1, 100, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_eq("rerun_valid", valid_w[2], 1);
    check_eq("rerun_first_k", fk_w[2], 1);
    check_eq("rerun_last_k", lk_w[2], 1);
    start_s[2] = 1'b0;
    ready_s[2] = 1'b1;
    @(posedge clk); #1;
    check_eq("rerun_done", done_w[2], 1);
    ready_s[2] = 1'b0;
    @(posedge clk); #1;
    check_idle(2, "rerun_idle");
    $display("run inst=2 rerun with held start complete");

    run_check(0, 1, 8, 16, 80, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
